// File: rtl/fp_pkg.sv
// Shared widths, mantissa bit positions, FSM states and flag layout for the
// FP normalize/round stage.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    // Raw mantissa layout from the adder: {carry, hidden, frac, G, R, S}
    localparam int S_BIT      = 0;
    localparam int R_BIT      = 1;
    localparam int G_BIT      = 2;
    localparam int FRAC_LSB   = 3;
    localparam int HIDDEN_BIT = FRAC_W + FRAC_LSB;
    localparam int CARRY_BIT  = HIDDEN_BIT + 1;
    localparam int MANT_W     = FRAC_W + 5;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        OUT
    } state_t;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
        logic zero;
    } flags_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of {hidden, frac} using guard/round/sticky; reports
// carry-out of the increment and whether any discarded bits were nonzero.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int FRAC_W = 23
) (
    input  logic              hidden,
    input  logic [FRAC_W-1:0] frac,
    input  logic              guard,
    input  logic              rnd,
    input  logic              sticky,
    output logic [FRAC_W:0]   mant_out,
    output logic              mant_ovf,
    output logic              inexact
);

    function automatic logic rne_incr(input logic g, input logic r,
                                      input logic s, input logic lsb);
        return g & (r | s | lsb);
    endfunction

    logic [FRAC_W+1:0] sum;

    always_comb begin
        sum      = {1'b0, hidden, frac} + {{(FRAC_W+1){1'b0}}, rne_incr(guard, rnd, sticky, frac[0])};
        mant_ovf = sum[FRAC_W+1];
        // On carry-out the significand is exactly 10...0, so dropping the LSB loses nothing
        mant_out = mant_ovf ? sum[FRAC_W+1:1] : sum[FRAC_W:0];
        inexact  = guard | rnd | sticky;
    end

endmodule

// File: rtl/fp_norm_round.sv
// Iterative normalize + RNE round of the FP adder's raw sum into a packed
// binary32 word with {overflow, underflow, inexact, zero} flags.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W      = 8,
    parameter int FRAC_W     = 23,
    parameter int SHIFT_STEP = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [FRAC_W+4:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_result,
    output logic [3:0]              out_flags
);

    localparam int MW  = FRAC_W + 5;
    localparam int HID = FRAC_W + FRAC_LSB;
    localparam int CAR = HID + 1;
    localparam int EW  = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
    localparam logic signed [EW-1:0] EXP_INF = EW'((1 << EXP_W) - 1);

    state_t                   state_q, state_d;
    logic                     sign_q, sign_d;
    logic signed [EW-1:0]     exp_q, exp_d, exp_rnd;
    logic [MW-1:0]            mant_q, mant_d;
    logic                     out_valid_q, out_valid_d;
    logic [EXP_W+FRAC_W:0]    out_result_q, out_result_d;
    flags_t                   out_flags_q, out_flags_d;

    logic [FRAC_W:0]          mant_rnd;
    logic                     mant_ovf;
    logic                     inexact;
    logic [EXP_W-1:0]         exp_field;
    logic                     lz_found;
    int                       lz, k, exp_m1;

    fp_round_rne #(.FRAC_W(FRAC_W)) u_round (
        .hidden   (mant_q[HID]),
        .frac     (mant_q[HID-1:FRAC_LSB]),
        .guard    (mant_q[G_BIT]),
        .rnd      (mant_q[R_BIT]),
        .sticky   (mant_q[S_BIT]),
        .mant_out (mant_rnd),
        .mant_ovf (mant_ovf),
        .inexact  (inexact)
    );

    // Left-shift amount: bounded by step size, leading zeros, and the denormal floor
    always_comb begin
        lz       = 0;
        lz_found = 1'b0;
        for (int i = HID; i >= 0; i--) begin
            if (!lz_found) begin
                if (mant_q[i]) lz_found = 1'b1;
                else           lz = lz + 1;
            end
        end
        exp_m1 = int'(exp_q) - 1;
        k      = SHIFT_STEP;
        if (lz < k)     k = lz;
        if (exp_m1 < k) k = exp_m1;
    end

    always_comb begin
        state_d      = state_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        mant_d       = mant_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        exp_rnd      = exp_q + $signed({{(EW-1){1'b0}}, mant_ovf});
        exp_field    = mant_rnd[FRAC_W] ? exp_rnd[EXP_W-1:0] : '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = (in_exp == '0) ? EXP_ONE : $signed({2'b00, in_exp});
                    mant_d  = in_mant;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mant_q == '0) begin
                    out_result_d     = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
                    out_flags_d      = '0;
                    out_flags_d.zero = 1'b1;
                    out_valid_d      = 1'b1;
                    state_d          = OUT;
                end else if (mant_q[CAR]) begin
                    mant_d  = {1'b0, mant_q[MW-1:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = ROUND;
                end else if (mant_q[HID] || exp_q <= EXP_ONE) begin
                    state_d = ROUND;
                end else begin
                    mant_d = mant_q << k;
                    exp_d  = exp_q - EW'(k);
                end
            end
            ROUND: begin
                out_flags_d = '0;
                if (exp_rnd >= EXP_INF) begin
                    out_result_d         = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    out_flags_d.overflow = 1'b1;
                    out_flags_d.inexact  = 1'b1;
                end else begin
                    out_result_d          = {sign_q, exp_field, mant_rnd[FRAC_W-1:0]};
                    out_flags_d.inexact   = inexact;
                    out_flags_d.underflow = (exp_field == '0) & inexact;
                end
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

    // Working operand registers are only meaningful while busy
    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        exp_q  <= exp_d;
        mant_q <= mant_d;
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboarded bench for fp_norm_round (SHIFT_STEP=1 main instance plus a
// SHIFT_STEP=4 instance for the multi-position shift case).
module tb_fp_norm_round;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_sign = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_exp = '0;
    logic [27:0] in_mant = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    logic        in4_valid = 1'b0, in4_sign = 1'b0, out4_ready = 1'b1;
    logic [7:0]  in4_exp = '0;
    logic [27:0] in4_mant = '0;
    logic        in4_ready, out4_valid;
    logic [31:0] out4_result;
    logic [3:0]  out4_flags;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_norm_round #(.EXP_W(8), .FRAC_W(23), .SHIFT_STEP(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    fp_norm_round #(.EXP_W(8), .FRAC_W(23), .SHIFT_STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in4_valid), .in_ready(in4_ready),
        .in_sign(in4_sign), .in_exp(in4_exp), .in_mant(in4_mant),
        .out_valid(out4_valid), .out_ready(out4_ready),
        .out_result(out4_result), .out_flags(out4_flags)
    );

    // Latency counts the handshake cycle as cycle 1; lat=0 skips the latency check.
    task automatic send(input string nm, input logic s, input logic [7:0] e,
                        input logic [27:0] m, input logic [31:0] r,
                        input logic [3:0] f, input int lat);
        exp_t x;
        int   n;
        @(negedge clk);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: in_ready=%b expected 1", nm, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x.name = nm; x.res = r; x.flg = f; x.lat = lat; x.acc = cyc;
        sb.push_back(x);
    endtask

    task automatic collect();
        exp_t x;
        int   n;
        int   lat;
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        x = sb.pop_front();
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: out_valid=%b expected 1", x.name, out_valid);
            return;
        end
        lat = cyc - x.acc + 1;
        total++;
        if (out_result !== x.res) begin
            bad++;
            $display("FAIL %s result: got %h expected %h", x.name, out_result, x.res);
        end
        total++;
        if (out_flags !== x.flg) begin
            bad++;
            $display("FAIL %s flags: got %b expected %b", x.name, out_flags, x.flg);
        end
        if (x.lat > 0) begin
            total++;
            if (lat != x.lat) begin
                bad++;
                $display("FAIL %s latency: got %0d expected %0d", x.name, lat, x.lat);
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s release: out_valid=%b in_ready=%b expected 0/1", x.name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0 || out_flags !== 4'h0) begin
            bad++;
            $display("FAIL reset_state: v=%b rdy=%b res=%h flg=%b expected 0/1/0/0",
                     out_valid, in_ready, out_result, out_flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normalized();
        send("normalized", 1'b0, 8'(BIAS), {2'b01, 23'h0, 3'b000}, 32'h3F800000, 4'b0000, 3);
        collect();
    endtask

    task automatic test_carry();
        send("carry", 1'b0, 8'(BIAS), {2'b10, 23'h0, 3'b000}, 32'h40000000, 4'b0000, 3);
        collect();
        // carry shift exposes a tie at G; sticky from the shifted-out bit breaks it
        send("carry_tie", 1'b0, 8'(BIAS), {2'b10, 23'h1, 3'b000}, 32'h40000000, 4'b0010, 3);
        collect();
        send("carry_sticky", 1'b0, 8'(BIAS), {2'b10, 23'h1, 3'b001}, 32'h40000001, 4'b0010, 3);
        collect();
    endtask

    task automatic test_cancel();
        send("cancel_s1", 1'b0, 8'h85, 28'h1 << 22, 32'h40800000, 4'b0000, 7);
        collect();
        // normalization stops at the denormal floor after two shifts
        send("exp_floor", 1'b0, 8'h03, 28'h1 << 20, 32'h00080000, 4'b0000, 5);
        collect();
    endtask

    task automatic test_cancel_step4();
        int a;
        int n;
        @(negedge clk);
        in4_valid = 1'b1; in4_sign = 1'b0; in4_exp = 8'h85; in4_mant = 28'h1 << 22;
        @(posedge clk);
        #1;
        in4_valid = 1'b0;
        a = cyc;
        n = 0;
        while (out4_valid !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (out4_result !== 32'h40800000 || out4_flags !== 4'b0000) begin
            bad++;
            $display("FAIL cancel_s4 result: got %h/%b expected 40800000/0000", out4_result, out4_flags);
        end
        total++;
        if (out4_valid !== 1'b1 || cyc - a + 1 != 4) begin
            bad++;
            $display("FAIL cancel_s4 latency: got %0d valid=%b expected 4", cyc - a + 1, out4_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rne_ties();
        send("tie_odd", 1'b0, 8'(BIAS), {2'b01, 23'h000001, 3'b100}, 32'h3F800002, 4'b0010, 3);
        collect();
        send("tie_even", 1'b0, 8'(BIAS), {2'b01, 23'h000000, 3'b100}, 32'h3F800000, 4'b0010, 3);
        collect();
    endtask

    task automatic test_overflow();
        send("overflow", 1'b0, 8'(EXP_MAX - 1), {2'b01, 23'h7FFFFF, 3'b110}, 32'h7F800000, 4'b1010, 3);
        collect();
    endtask

    task automatic test_denormal();
        send("denorm_exact", 1'b0, 8'h00, {2'b00, 23'h000001, 3'b000}, 32'h00000001, 4'b0000, 3);
        collect();
        send("denorm_uflow", 1'b1, 8'h00, {2'b00, 23'h000001, 3'b101}, 32'h80000002, 4'b0110, 3);
        collect();
        send("denorm_to_norm", 1'b0, 8'h00, {2'b00, 23'h7FFFFF, 3'b100}, 32'h00800000, 4'b0010, 3);
        collect();
    endtask

    task automatic test_zero_backpressure();
        int n;
        int lat;
        logic ok;
        out_ready = 1'b0;
        send("zero", 1'b1, 8'h40, 28'h0, 32'h80000000, 4'b0001, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        lat = cyc - sb[0].acc + 1;
        total++;
        if (out_valid !== 1'b1 || lat != 2) begin
            bad++;
            $display("FAIL zero latency: got %0d valid=%b expected 2", lat, out_valid);
        end
        // offered input during the stall must be ignored
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'(BIAS); in_mant = {2'b10, 26'h0};
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_result !== 32'h80000000 || out_flags !== 4'b0001) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stall_hold: v=%b rdy=%b res=%h flg=%b expected 1/0/80000000/0001",
                     out_valid, in_ready, out_result, out_flags);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        collect();
    endtask

    task automatic test_back_to_back();
        send("b2b_0", 1'b1, 8'h80, {2'b01, 23'h400000, 3'b000}, 32'hC0400000, 4'b0000, 3);
        collect();
        send("b2b_1", 1'b0, 8'h7E, {2'b00, 23'h400000, 3'b000}, 32'h3E800000, 4'b0000, 4);
        collect();
        send("b2b_2", 1'b0, 8'(BIAS), {2'b01, 23'h000000, 3'b011}, 32'h3F800000, 4'b0010, 3);
        collect();
    endtask

    task automatic test_reset_midflight();
        logic ok;
        send("dropped", 1'b0, 8'h85, 28'h1 << 22, 32'h0, 4'b0000, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0 || out_flags !== 4'h0) begin
            bad++;
            $display("FAIL async_reset: v=%b rdy=%b res=%h flg=%b expected 0/1/0/0",
                     out_valid, in_ready, out_result, out_flags);
        end
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL reset_drop: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        send("after_reset", 1'b0, 8'(BIAS), {2'b10, 26'h0}, 32'h40000000, 4'b0000, 3);
        collect();
    endtask

    initial begin
        test_reset();
        test_normalized();
        test_carry();
        test_cancel();
        test_cancel_step4();
        test_rne_ties();
        test_overflow();
        test_denormal();
        test_zero_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
